decode_issue_ctrl: RTL and testbench
====================================

Name: decode_issue_ctrl

Overview:
- Single-entry decode-stage controller between instruction fetch and execute.
- Accepts fetched instructions over a valid/ready handshake and classifies each opcode into an immediate type.
- Holds the instruction, PC and immediate-type select that drive the immediate generator and the downstream decoder.
- Issues to execute under stall and flush control, and traps illegal encodings.

Parameters:
CNT_W, 16, width of the issued-instruction counter

Ports:
clk  input  1  system clock, rising edge
nrst  input  1  asynchronous active-low reset
if_valid  input  1  fetch presents an instruction
if_inst  input  32  fetched instruction word
if_pc  input  32  PC of the fetched instruction
if_ready  output  1  controller accepts if_inst/if_pc this cycle
flush  input  1  discard held instruction (branch/jump/trap redirect)
hazard_stall  input  1  execute-side hazard; block issue
ex_ready  input  1  execute stage can take an instruction
id_valid  output  1  held instruction valid to execute
id_inst  output  32  held instruction
id_pc  output  32  held PC
imm_type  output  3  immediate-type select to the immediate generator
illegal  output  1  illegal instruction trapped (level)
issued_cnt  output  CNT_W  count of issued instructions

Behaviour:
- One clock (clk); reset asynchronous, active-low (nrst).
- Reset values:
  - state = EMPTY.
  - id_valid=0, id_inst=0, id_pc=0, imm_type=0, illegal=0, issued_cnt=0.
- imm_type encoding:
  - 0 none (R-type; generator output treated as 0)
  - 1 I, 2 S, 3 SB, 4 U, 5 UJ
  - 6 and 7 are never driven.
- Opcode map on inst[6:0]:
  - 0110011 -> 0
  - 0010011, 0000011, 1100111, 1110011, 0001111 -> 1
  - 0100011 -> 2
  - 1100011 -> 3
  - 0110111, 0010111 -> 4
  - 1101111 -> 5
  - any other opcode -> illegal. inst[1:0]!=2'b11 is covered by this rule.
- Handshake definitions:
  - accept = if_valid & if_ready.
  - issue = id_valid & ex_ready & ~hazard_stall.
- FSM states: EMPTY, FULL, TRAP.
  - EMPTY:
    - if_ready = ~flush; id_valid=0.
    - On accept of a legal opcode: load id_inst, id_pc, imm_type (registered, same edge) -> FULL.
    - On accept of an illegal opcode: load id_inst/id_pc, imm_type=0, illegal=1 -> TRAP.
  - FULL:
    - id_valid=1.
    - if_ready = issue & ~flush (combinational path from ex_ready/hazard_stall is intended).
    - On issue with accept: reload with the new instruction; stay FULL, or go to TRAP if the new opcode is illegal. Back-to-back gives 1 instruction/cycle.
    - On issue without accept -> EMPTY.
    - No issue: hold all outputs stable.
  - TRAP:
    - id_valid=0, if_ready=0, illegal=1 held.
    - id_inst/id_pc hold the offending word/PC for trap handling.
    - Exits only on flush.
- Flush has highest priority in every state:
  - Next state EMPTY, id_valid=0, illegal=0.
  - An instruction presented in the same cycle is not accepted (if_ready=0).
  - An issue coinciding with flush still counts. Execute sampled it, and the redirect decision belongs to the flusher.
- Latency: an instruction accepted at edge N is presented with id_valid=1 after edge N; earliest issue is cycle N+1.
- issued_cnt:
  - Increments by 1 on each issue.
  - Wraps from 2^CNT_W-1 to 0.
  - Never increments in TRAP.
- Reset asserted mid-operation returns to the reset values immediately and drops the held instruction.
- id_inst/id_pc/imm_type change only on accept or reset; flush clears only id_valid and illegal.

Test Plan:
- Reset, then if_valid with 0x00500093 (addi) while ex_ready=1 -> one cycle later id_valid=1, imm_type=1, id_pc=if_pc; issue next cycle, issued_cnt=1.
- Stream sw 0x0020A223, beq 0x00208463, lui 0x000012B7, jal 0x008000EF with ex_ready=1 every cycle -> one issue per cycle, imm_type sequence 2,3,4,5, if_ready stays 1, issued_cnt=4.
- FULL with hazard_stall=1 for 3 cycles and if_valid=1 -> if_ready=0, id_* stable for 3 cycles; stall drops -> issue and accept of the next instruction on the same edge.
- Accept 0xFFFFFFFF -> TRAP, illegal=1, id_valid=0, if_ready=0 held 5 cycles, issued_cnt unchanged; flush -> EMPTY, illegal=0 next cycle.
- FULL, flush with if_valid=1 same cycle -> next cycle EMPTY, id_valid=0, that instruction not accepted (if_ready was 0).
- CNT_W=4, issue 17 instructions -> issued_cnt=1 (wrapped); assert nrst low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/decode_issue_ctrl.sv
// Purpose: single-entry decode slot between fetch and execute; classifies opcode into immediate type, traps illegal encodings.
// Latency: instruction accepted at edge N is presented (id_valid) after edge N; 1 instruction/cycle sustained when execute keeps up.
// Backpressure: if_ready drops while the slot is held and not issuing, during TRAP, and whenever flush is high.
//
// Ports:
//   clk, nrst                      clock, asynchronous active-low reset
//   if_valid/if_ready/if_inst/if_pc fetch-side valid/ready handshake
//   flush                          redirect: drops held instruction and trap
//   hazard_stall, ex_ready         execute-side issue gating
//   id_valid/id_inst/id_pc         held instruction to execute
//   imm_type                       immediate-generator select (0 none,1 I,2 S,3 SB,4 U,5 UJ)
//   illegal                        level trap flag, held until flush
//   issued_cnt                     wrapping count of issued instructions
module decode_issue_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             if_valid,
    input  logic [31:0]      if_inst,
    input  logic [31:0]      if_pc,
    output logic             if_ready,
    input  logic             flush,
    input  logic             hazard_stall,
    input  logic             ex_ready,
    output logic             id_valid,
    output logic [31:0]      id_inst,
    output logic [31:0]      id_pc,
    output logic [2:0]       imm_type,
    output logic             illegal,
    output logic [CNT_W-1:0] issued_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        TRAP  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       dec_legal;
    logic [2:0] dec_imm;
    logic       issue;
    logic       accept;

    // Opcode classification of the word presented by fetch.
    always_comb begin
        dec_legal = 1'b1;
        dec_imm   = 3'd0;
        case (if_inst[6:0])
            7'b0110011: dec_imm = 3'd0;
            7'b0010011,
            7'b0000011,
            7'b1100111,
            7'b1110011,
            7'b0001111: dec_imm = 3'd1;
            7'b0100011: dec_imm = 3'd2;
            7'b1100011: dec_imm = 3'd3;
            7'b0110111,
            7'b0010111: dec_imm = 3'd4;
            7'b1101111: dec_imm = 3'd5;
            default: begin
                dec_legal = 1'b0;
                dec_imm   = 3'd0;
            end
        endcase
    end

    // Handshake and next-state logic. Flush overrides everything, but an
    // issue in the flush cycle still happened from execute's point of view.
    always_comb begin
        id_valid  = 1'b0;
        if_ready  = 1'b0;
        issue     = 1'b0;
        accept    = 1'b0;
        state_nxt = state;
        case (state)
            EMPTY: begin
                if_ready = ~flush;
                accept   = if_valid & if_ready;
                if (accept) begin
                    state_nxt = dec_legal ? FULL : TRAP;
                end
            end
            FULL: begin
                id_valid = 1'b1;
                issue    = ex_ready & ~hazard_stall;
                // Refill in the same cycle as issue: combinational from ex_ready.
                if_ready = issue & ~flush;
                accept   = if_valid & if_ready;
                if (issue) begin
                    if (accept) begin
                        state_nxt = dec_legal ? FULL : TRAP;
                    end else begin
                        state_nxt = EMPTY;
                    end
                end
            end
            TRAP: begin
                state_nxt = TRAP;
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
        if (flush) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Held instruction fields change only on accept so a trapped word stays
    // visible to the trap handler; flush touches only the valid/illegal flags.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            id_inst    <= 32'd0;
            id_pc      <= 32'd0;
            imm_type   <= 3'd0;
            illegal    <= 1'b0;
            issued_cnt <= '0;
        end else begin
            if (accept) begin
                id_inst  <= if_inst;
                id_pc    <= if_pc;
                imm_type <= dec_legal ? dec_imm : 3'd0;
            end
            if (flush) begin
                illegal <= 1'b0;
            end else if (accept) begin
                illegal <= ~dec_legal;
            end
            if (issue) begin
                issued_cnt <= issued_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
module tb_decode_issue_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          nrst;
    logic          if_valid;
    logic [31:0]   if_inst;
    logic [31:0]   if_pc;
    logic          if_ready;
    logic          flush;
    logic          hazard_stall;
    logic          ex_ready;
    logic          id_valid;
    logic [31:0]   id_inst;
    logic [31:0]   id_pc;
    logic [2:0]    imm_type;
    logic          illegal;
    logic [CW-1:0] issued_cnt;

    decode_issue_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .nrst(nrst),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_ready(if_ready),
        .flush(flush), .hazard_stall(hazard_stall), .ex_ready(ex_ready),
        .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
        .imm_type(imm_type), .illegal(illegal), .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;

    // Reference model: a one-deep slot described by what it holds.
    int   imm_of [128];   // -1 means illegal opcode
    bit   m_hold;         // an instruction is waiting for execute
    bit   m_trap;         // an illegal word is parked
    int   m_inst;
    int   m_pc;
    int   m_imm;
    int   m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic bit exp_ready();
        if (m_trap) return 1'b0;
        if (!m_hold) return !flush;
        return ex_ready && !hazard_stall && !flush;
    endfunction

    task automatic model_reset();
        m_hold = 0; m_trap = 0; m_inst = 0; m_pc = 0; m_imm = 0; m_cnt = 0;
    endtask

    // Compare every output against the model, then advance one clock.
    task automatic step();
        bit rdy, iss, acc;
        int code;
        #1;
        rdy = exp_ready();
        check("if_ready",   {31'd0, if_ready},   {31'd0, rdy});
        check("id_valid",   {31'd0, id_valid},   {31'd0, m_hold});
        check("id_inst",    id_inst,             m_inst);
        check("id_pc",      id_pc,               m_pc);
        check("imm_type",   {29'd0, imm_type},   m_imm);
        check("illegal",    {31'd0, illegal},    {31'd0, m_trap});
        check("issued_cnt", {28'd0, issued_cnt}, m_cnt);
        iss = m_hold && ex_ready && !hazard_stall;
        acc = if_valid && rdy;
        if (iss) m_cnt = (m_cnt + 1) % (1 << CW);
        if (flush) begin
            m_hold = 0; m_trap = 0;
        end else if (acc) begin
            code   = imm_of[if_inst[6:0]];
            m_inst = if_inst;
            m_pc   = if_pc;
            m_imm  = (code < 0) ? 0 : code;
            m_hold = (code >= 0);
            m_trap = (code < 0);
        end else if (iss) begin
            m_hold = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                         input bit fl, input bit st, input bit er);
        if_valid = v; if_inst = inst; if_pc = pc;
        flush = fl; hazard_stall = st; ex_ready = er;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [11];
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        if ($urandom_range(0, 3) == 0) return $urandom;
        return {$urandom_range(0, 32'h01FF_FFFF), ops[$urandom_range(0, 10)]};
    endfunction

    logic [31:0] stream [4];

    initial begin
        for (int i = 0; i < 128; i++) imm_of[i] = -1;
        imm_of[7'h33] = 0;
        imm_of[7'h13] = 1; imm_of[7'h03] = 1; imm_of[7'h67] = 1;
        imm_of[7'h73] = 1; imm_of[7'h0F] = 1;
        imm_of[7'h23] = 2; imm_of[7'h63] = 3;
        imm_of[7'h37] = 4; imm_of[7'h17] = 4;
        imm_of[7'h6F] = 5;

        // Reset
        nrst = 1'b0;
        drive(0, 32'd0, 32'd0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        step();

        // addi, then issue
        drive(1, 32'h00500093, 32'h0000_0100, 0, 0, 1);
        step();
        drive(0, 32'd0, 32'd0, 0, 0, 1);
        step();
        step();

        // Back-to-back stream sw/beq/lui/jal
        stream = '{32'h0020A223, 32'h00208463, 32'h000012B7, 32'h008000EF};
        for (int i = 0; i < 4; i++) begin
            drive(1, stream[i], 32'h200 + 4 * i, 0, 0, 1);
            step();
        end
        drive(0, 32'd0, 32'd0, 0, 0, 1);
        step();
        step();

        // Stall with fetch waiting
        drive(1, 32'h00A00113, 32'h300, 0, 0, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h00B00193, 32'h304, 0, 1, 1);
            step();
        end
        drive(1, 32'h00B00193, 32'h304, 0, 0, 1);
        step();
        drive(0, 32'd0, 32'd0, 0, 0, 1);
        step();
        step();

        // Illegal word: trap, hold, flush out
        drive(1, 32'hFFFFFFFF, 32'h400, 0, 0, 1);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h00500093, 32'h404, 0, 0, 1);
            step();
        end
        drive(1, 32'h00500093, 32'h404, 1, 0, 1);
        step();
        drive(0, 32'd0, 32'd0, 0, 0, 0);
        step();

        // Flush while full with fetch presenting
        drive(1, 32'h00C00213, 32'h500, 0, 0, 0);
        step();
        drive(1, 32'h00D00293, 32'h504, 1, 0, 0);
        step();
        drive(0, 32'd0, 32'd0, 0, 0, 1);
        step();

        // 17 back-to-back issues: 4-bit counter wraps
        for (int i = 0; i < 17; i++) begin
            drive(1, 32'h00100013 | (i << 20), 32'h600 + 4 * i, 0, 0, 1);
            step();
        end
        drive(0, 32'd0, 32'd0, 0, 0, 1);
        step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, rand_inst(), $urandom,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) != 0);
            step();
        end

        // Asynchronous reset mid-stream
        drive(1, 32'h00500093, 32'h700, 0, 0, 0);
        step();
        #2 nrst = 1'b0;
        #1;
        check("async_id_valid", {31'd0, id_valid}, 32'd0);
        check("async_id_inst",  id_inst,           32'd0);
        check("async_id_pc",    id_pc,             32'd0);
        check("async_imm_type", {29'd0, imm_type}, 32'd0);
        check("async_illegal",  {31'd0, illegal},  32'd0);
        check("async_cnt",      {28'd0, issued_cnt}, 32'd0);
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        drive(0, 32'd0, 32'd0, 0, 0, 1);
        step();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
